// File: rtl/merge_wb_pkg.sv
// Shared types and constants for the root merge write burst buffer.
package merge_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_FIN
  } state_t;

  // 512-bit memory beats per 2048-bit root bundle
  localparam int RATIO = 4;
  // bytes carried by one 512-bit memory beat
  localparam int BEAT_BYTES = 64;
  // AXI write response code for a successful write
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/merge_root_write_burst_fifo.sv
// First-word-fall-through beat FIFO with occupancy count.
module wb_beat_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 128
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

  // Pointer and occupancy update; push and pop together leave the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (PTR_W+1)'(1);
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  // Pointer/count registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/merge_root_write_burst.sv
// Write burst buffer behind the phase-2 root merge: splits root bundles into
// memory beats and writes them out as serialized AXI4 INCR bursts.
module merge_root_write_burst
  import merge_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ROOT_WIDTH = 32 * DATA_WIDTH,
  parameter int AXI_WIDTH  = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [31:0]           i_num_bundles,
  input  logic [ROOT_WIDTH-1:0] i_root_data,
  input  logic                  i_root_data_vld,
  output logic                  o_root_read,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic [7:0]            o_awlen,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  output logic [AXI_WIDTH-1:0]  o_wdata,
  output logic                  o_wlast,
  input  logic                  i_bvalid,
  input  logic [1:0]            i_bresp,
  output logic                  o_bready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int IDX_W = $clog2(RATIO);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  // address step between bursts: one full burst (4 KB by default)
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * BEAT_BYTES);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [33:0]           remaining_q, remaining_d;
  logic [31:0]           num_q, num_d;
  logic [31:0]           popped_q, popped_d;
  logic [ROOT_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  error_q, error_d;

  logic [33:0]           total_beats;
  logic [7:0]            cur_len;
  logic                  active, push, last_push, root_read, start_ok;
  logic                  awvalid, wvalid, wlast, fifo_pop;
  logic                  fifo_empty, fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic [AXI_WIDTH-1:0]  fifo_data;
  logic [AXI_WIDTH-1:0]  slice [RATIO];

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_slice
      assign slice[gi] = hold_q[gi*AXI_WIDTH +: AXI_WIDTH];
    end
  endgenerate

  assign total_beats = 34'(i_num_bundles) * 34'(RATIO);
  assign cur_len     = (remaining_q >= 34'(BURST_LEN)) ? 8'(BURST_LEN) : remaining_q[7:0];
  assign active      = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_RESP);
  assign start_ok    = (state_q == ST_IDLE) && i_start;
  assign push        = active && hold_vld_q && !fifo_full;
  assign last_push   = push && (idx_q == IDX_W'(RATIO - 1));
  // Refill on the same edge the last slice leaves, so bundles stream without a bubble.
  assign root_read   = active && (!hold_vld_q || last_push) && i_root_data_vld
                       && (popped_q < num_q);

  wb_beat_fifo #(
    .WIDTH (AXI_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (slice[idx_q]),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_count (fifo_count)
  );

  // Downsizer: holding register walks its slices LSB first into the beat FIFO.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    idx_d      = idx_q;
    popped_d   = popped_q;
    if (root_read) begin
      hold_d     = i_root_data;
      hold_vld_d = 1'b1;
      idx_d      = '0;
      popped_d   = popped_q + 32'd1;
    end else if (push) begin
      idx_d = idx_q + IDX_W'(1);
      if (last_push) hold_vld_d = 1'b0;
    end
    if (start_ok) begin
      hold_vld_d = 1'b0;
      idx_d      = '0;
      popped_d   = '0;
    end
  end

  // Burst FSM next state and AXI channel outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    num_d       = num_q;
    beat_cnt_d  = beat_cnt_q;
    error_d     = error_q;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    wlast       = 1'b0;
    fifo_pop    = 1'b0;
    o_bready    = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d      = i_base_addr;
          num_d       = i_num_bundles;
          remaining_d = total_beats;
          beat_cnt_d  = '0;
          error_d     = 1'b0;
          state_d     = (total_beats == '0) ? ST_FIN : ST_ADDR;
        end
      end
      ST_ADDR: begin
        o_busy = 1'b1;
        // The whole burst is already buffered before AW goes out, so W never starves.
        awvalid = 32'(fifo_count) >= 32'(cur_len);
        if (awvalid && i_awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        o_busy = 1'b1;
        wvalid = !fifo_empty;
        wlast  = wvalid && (beat_cnt_q == cur_len - 8'd1);
        if (wvalid && i_wready) begin
          fifo_pop = 1'b1;
          if (wlast) begin
            beat_cnt_d = '0;
            state_d    = ST_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      ST_RESP: begin
        o_busy   = 1'b1;
        o_bready = 1'b1;
        if (i_bvalid) begin
          if (i_bresp != RESP_OKAY) error_d = 1'b1;
          remaining_d = remaining_q - 34'(cur_len);
          addr_d      = addr_q + BURST_BYTES;
          state_d     = (remaining_d != '0) ? ST_ADDR : ST_FIN;
        end
      end
      ST_FIN: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_root_read = root_read;
  assign o_awvalid   = awvalid;
  assign o_awaddr    = awvalid ? addr_q : '0;
  assign o_awlen     = awvalid ? (cur_len - 8'd1) : 8'd0;
  assign o_wvalid    = wvalid;
  assign o_wdata     = wvalid ? fifo_data : '0;
  assign o_wlast     = wlast;
  assign o_error     = error_q;

  // State, counter and holding registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      num_q       <= '0;
      popped_q    <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      idx_q       <= '0;
      beat_cnt_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      num_q       <= num_d;
      popped_q    <= popped_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      idx_q       <= idx_d;
      beat_cnt_q  <= beat_cnt_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_merge_root_write_burst.sv
// Bench for merge_root_write_burst: scenario table plus random runs, checked
// against bundle/burst expectations computed from the transfer rules.
module tb_merge_root_write_burst;

  localparam int RW  = 2048;
  localparam int AXW = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            i_start = 1'b0;
  logic [63:0]     i_base_addr = '0;
  logic [31:0]     i_num_bundles = '0;
  logic [RW-1:0]   i_root_data = '0;
  logic            i_root_data_vld = 1'b0;
  logic            i_awready = 1'b0;
  logic            i_wready = 1'b0;
  logic            i_bvalid = 1'b0;
  logic [1:0]      i_bresp = 2'b00;
  logic            o_root_read, o_awvalid, o_wvalid, o_wlast, o_bready;
  logic            o_busy, o_done, o_error;
  logic [63:0]     o_awaddr;
  logic [7:0]      o_awlen;
  logic [AXW-1:0]  o_wdata;

  merge_root_write_burst dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (i_start),
    .i_base_addr     (i_base_addr),
    .i_num_bundles   (i_num_bundles),
    .i_root_data     (i_root_data),
    .i_root_data_vld (i_root_data_vld),
    .o_root_read     (o_root_read),
    .o_awvalid       (o_awvalid),
    .i_awready       (i_awready),
    .o_awaddr        (o_awaddr),
    .o_awlen         (o_awlen),
    .o_wvalid        (o_wvalid),
    .i_wready        (i_wready),
    .o_wdata         (o_wdata),
    .o_wlast         (o_wlast),
    .i_bvalid        (i_bvalid),
    .i_bresp         (i_bresp),
    .o_bready        (o_bready),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_error         (o_error)
  );

  typedef struct {
    int          num;
    logic [63:0] base;
    int          stall;
    int          err_burst;
    int          exp_naw;
    bit          exp_err;
  } vec_t;

  // configuration and source data, written only by the test process
  logic [RW-1:0] bundle_mem [64];
  int            cfg_stall = 0;
  int            cfg_err_burst = -1;
  int            cfg_avail = 0;

  // observations, written only by the driver/monitor process
  int            root_pops = 0, aw_cnt = 0, w_cnt = 0, b_owed = 0, b_issued = 0;
  int            b_acc = 0, b_acc_seen = 0, done_cnt = 0, stab_err = 0, serial_err = 0;
  int            cyc = 0, start_cyc = 0, done_cyc = 0, b_at_done = 0;
  bit            err_at_done = 1'b0, outstanding = 1'b0, p_aw_pend = 1'b0, p_w_pend = 1'b0;
  logic [63:0]   p_awaddr = '0;
  logic [7:0]    p_awlen = '0;
  logic [AXW-1:0] p_wdata = '0;
  logic          p_wlast = 1'b0;
  logic [63:0]   obs_awaddr [8];
  logic [7:0]    obs_awlen [8];
  logic [AXW-1:0] obs_wdata [256];
  logic          obs_wlast [256];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void chk_wide(string name, logic [AXW-1:0] act, logic [AXW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Environment: drive ready/valid/source just after posedge, observe at negedge.
  always begin
    @(posedge clk);
    #1;
    if (b_acc != b_acc_seen) begin
      i_bvalid   = 1'b0;
      b_acc_seen = b_acc;
    end
    if (!i_bvalid && (b_issued < b_owed) && (cfg_stall == 0 || $urandom_range(0, 1) == 1)) begin
      i_bvalid = 1'b1;
      i_bresp  = (b_issued == cfg_err_burst) ? 2'b10 : 2'b00;
      b_issued++;
    end
    i_awready       = (cfg_stall == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    i_wready        = (cfg_stall == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    i_root_data_vld = (root_pops < cfg_avail) && (cfg_stall == 0 || $urandom_range(0, 3) != 0);
    i_root_data     = (root_pops < 64) ? bundle_mem[root_pops] : '0;

    @(negedge clk);
    cyc++;
    if (o_root_read) root_pops++;
    if (o_done) begin
      done_cnt++;
      err_at_done = o_error;
      done_cyc    = cyc;
      b_at_done   = b_acc;
    end
    if (p_aw_pend && !(o_awvalid && o_awaddr == p_awaddr && o_awlen == p_awlen)) stab_err++;
    if (p_w_pend && !(o_wvalid && o_wdata == p_wdata && o_wlast == p_wlast)) stab_err++;
    if (o_awvalid && outstanding) serial_err++;
    if (o_awvalid && i_awready) begin
      if (aw_cnt < 8) begin
        obs_awaddr[aw_cnt] = o_awaddr;
        obs_awlen[aw_cnt]  = o_awlen;
      end
      aw_cnt++;
      outstanding = 1'b1;
    end
    if (o_wvalid && i_wready) begin
      if (w_cnt < 256) begin
        obs_wdata[w_cnt] = o_wdata;
        obs_wlast[w_cnt] = o_wlast;
      end
      w_cnt++;
      if (o_wlast) b_owed++;
    end
    if (i_bvalid && o_bready) begin
      b_acc++;
      outstanding = 1'b0;
    end
    p_aw_pend = o_awvalid && !i_awready;
    p_awaddr  = o_awaddr;
    p_awlen   = o_awlen;
    p_w_pend  = o_wvalid && !i_wready;
    p_wdata   = o_wdata;
    p_wlast   = o_wlast;
    if (i_start) begin
      root_pops = 0; aw_cnt = 0; w_cnt = 0; b_owed = 0; b_issued = 0;
      b_acc = 0; b_acc_seen = 0; done_cnt = 0; stab_err = 0; serial_err = 0;
      outstanding = 1'b0; p_aw_pend = 1'b0; p_w_pend = 1'b0;
      start_cyc = cyc; i_bvalid = 1'b0;
    end
  end

  task automatic load_bundles(input int n);
    for (int j = 0; j < n && j < 64; j++)
      for (int w = 0; w < RW / 32; w++)
        bundle_mem[j][w*32 +: 32] = $urandom;
  endtask

  task automatic pulse_start(input int num, input logic [63:0] base);
    @(posedge clk);
    #1;
    i_num_bundles = 32'(num);
    i_base_addr   = base;
    i_start       = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    int          total, n_bursts, budget;
    logic [63:0] exp_addr [8];
    int          exp_len [8];
    logic [RW-1:0] bb;
    total    = v.num * 4;
    n_bursts = 0;
    for (int b = 0; b * 64 < total && b < 8; b++) begin
      exp_addr[b] = v.base + 64'(b) * 64'd4096;
      exp_len[b]  = ((total - b * 64) > 64 ? 64 : (total - b * 64)) - 1;
      n_bursts++;
    end
    cfg_stall     = v.stall;
    cfg_err_burst = v.err_burst;
    cfg_avail     = v.num + 2;
    load_bundles(v.num + 2);
    pulse_start(v.num, v.base);
    chk("start_error_clear", o_error, 0);
    chk("start_busy", o_busy, (v.num != 0) ? 1 : 0);
    chk("start_done", o_done, (v.num == 0) ? 1 : 0);
    budget = 0;
    while (done_cnt == 0 && budget < 6000) begin
      @(negedge clk);
      budget++;
    end
    chk("done_seen", (done_cnt != 0) ? 1 : 0, 1);
    repeat (8) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("aw_count", aw_cnt, v.exp_naw);
    chk("beat_count", w_cnt, total);
    chk("root_reads", root_pops, v.num);
    chk("b_count", b_acc, v.exp_naw);
    chk("done_after_last_b", b_at_done, v.exp_naw);
    chk("error_at_done", err_at_done, v.exp_err);
    chk("error_sticky", o_error, v.exp_err);
    chk("busy_after", o_busy, 0);
    chk("aw_w_stable", stab_err, 0);
    chk("one_outstanding", serial_err, 0);
    if (v.num == 0) chk("done_latency", done_cyc - start_cyc, 1);
    for (int b = 0; b < n_bursts && b < aw_cnt; b++) begin
      chk($sformatf("aw%0d_addr", b), obs_awaddr[b], exp_addr[b]);
      chk($sformatf("aw%0d_len", b), obs_awlen[b], exp_len[b]);
    end
    for (int k = 0; k < total && k < w_cnt && k < 256; k++) begin
      bb = bundle_mem[k / 4];
      chk_wide($sformatf("beat%0d_data", k), obs_wdata[k], bb[(k % 4)*AXW +: AXW]);
      chk($sformatf("beat%0d_wlast", k), obs_wlast[k],
          ((k % 64) == 63 || k == total - 1) ? 1 : 0);
    end
    $display("case bundles=%0d base=0x%0h stall=%0d: bursts=%0d beats=%0d root_reads=%0d error=%0d",
             v.num, v.base, v.stall, aw_cnt, w_cnt, root_pops, o_error);
  endtask

  initial begin
    vec_t vecs [6];
    vec_t v;
    int   budget;
    vecs[0] = '{16, 64'h1000,  0, -1, 1, 1'b0};
    vecs[1] = '{17, 64'h1000,  0, -1, 2, 1'b0};
    vecs[2] = '{0,  64'h3000,  0, -1, 0, 1'b0};
    vecs[3] = '{40, 64'h5000,  1, -1, 3, 1'b0};
    vecs[4] = '{32, 64'h8000,  0,  0, 2, 1'b1};
    vecs[5] = '{3,  64'h10000, 1, -1, 1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_awvalid", o_awvalid, 0);
    chk("reset_wvalid", o_wvalid, 0);
    chk("reset_root_read", o_root_read, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_error", o_error, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_case(vecs[i]);

    // Reset in the middle of a data phase, then a fresh short transfer.
    cfg_stall     = 1;
    cfg_err_burst = -1;
    cfg_avail     = 18;
    load_bundles(18);
    pulse_start(16, 64'h4000);
    budget = 0;
    while (w_cnt < 10 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    chk("mid_burst_reached", (w_cnt >= 10) ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_awvalid", o_awvalid, 0);
    chk("arst_awaddr", o_awaddr, 0);
    chk("arst_awlen", o_awlen, 0);
    chk("arst_wvalid", o_wvalid, 0);
    chk_wide("arst_wdata", o_wdata, '0);
    chk("arst_wlast", o_wlast, 0);
    chk("arst_bready", o_bready, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    chk("arst_error", o_error, 0);
    chk("arst_root_read", o_root_read, 0);
    repeat (3) @(negedge clk);
    chk("arst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    v = '{4, 64'h2000, 0, -1, 1, 1'b0};
    run_case(v);

    for (int r = 0; r < 3; r++) begin
      v.num       = $urandom_range(1, 40);
      v.base      = 64'($urandom_range(0, 1023)) << 12;
      v.stall     = 1;
      v.err_burst = -1;
      v.exp_naw   = (v.num * 4 + 63) / 64;
      v.exp_err   = 1'b0;
      run_case(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
